// File: rtl/serial_compare_arbiter.sv
// Round-robin arbiter feeding a bit-serial, MSB-first unsigned comparator.
// One request is in flight at a time; the result is held until it is consumed.
module serial_compare_arbiter #(
    parameter int W    = 8,
    parameter int NREQ = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*W-1:0]          req_a,
    input  logic [NREQ*W-1:0]          req_b,
    output logic [NREQ-1:0]            req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic                       rsp_lt,
    output logic                       rsp_eq,
    output logic                       rsp_gt,
    output logic [$clog2(W+1)-1:0]     rsp_bits,
    output logic                       busy
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(W+1);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        RESPOND
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_hit;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [BW-1:0]   cnt;
    logic            bit_diff;
    logic            last_bit;

    assign bit_diff = a_sh[W-1] != b_sh[W-1];
    assign last_bit = cnt == BW'(1);

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_hit && req_valid[(int'(last_grant) + k) % NREQ]) begin
                grant_hit = 1'b1;
                grant_idx = IW'((int'(last_grant) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        unique case (state)
            IDLE: begin
                if (grant_hit) begin
                    req_ready[grant_idx] = 1'b1;
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (bit_diff || last_bit) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            req_ready = '0;
        end
    end

    assign rsp_valid = state == RESPOND;
    assign busy      = state != IDLE;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= IW'(NREQ - 1);
            a_sh       <= '0;
            b_sh       <= '0;
            cnt        <= '0;
            rsp_id     <= '0;
            rsp_lt     <= 1'b0;
            rsp_eq     <= 1'b0;
            rsp_gt     <= 1'b0;
            rsp_bits   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_hit) begin
                        a_sh       <= req_a[int'(grant_idx)*W +: W];
                        b_sh       <= req_b[int'(grant_idx)*W +: W];
                        cnt        <= BW'(W);
                        rsp_id     <= grant_idx;
                        last_grant <= grant_idx;
                    end
                end
                COMPARE: begin
                    if (bit_diff) begin
                        rsp_lt   <= b_sh[W-1];
                        rsp_gt   <= a_sh[W-1];
                        rsp_bits <= BW'(W) - cnt + BW'(1);
                    end else if (last_bit) begin
                        rsp_eq   <= 1'b1;
                        rsp_bits <= BW'(W);
                    end else begin
                        a_sh <= a_sh << 1;
                        b_sh <= b_sh << 1;
                        cnt  <= cnt - BW'(1);
                    end
                end
                RESPOND: begin
                    // Flags must read all-zero whenever no result is offered.
                    if (rsp_ready) begin
                        rsp_lt <= 1'b0;
                        rsp_eq <= 1'b0;
                        rsp_gt <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_compare_arbiter.sv
// Randomised scoreboard bench for serial_compare_arbiter.
// Expected grants and results come from a behavioural model.
module tb_serial_compare_arbiter;

    localparam int W    = 8;
    localparam int NREQ = 4;
    localparam int IW   = 2;
    localparam int BW   = 4;

    logic                clock = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IW-1:0]       rsp_id;
    logic                rsp_lt;
    logic                rsp_eq;
    logic                rsp_gt;
    logic [BW-1:0]       rsp_bits;
    logic                busy;

    serial_compare_arbiter #(.W(W), .NREQ(NREQ)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_lt    (rsp_lt),
        .rsp_eq    (rsp_eq),
        .rsp_gt    (rsp_gt),
        .rsp_bits  (rsp_bits),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int id;
        bit lt;
        bit eq;
        bit gt;
        int bits;
        int due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    bit   m_busy = 1'b0;
    int   m_last = NREQ - 1;
    bit   was_reset = 1'b0;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d",
                      name, act, exp, cyc);
    endfunction

    // Monitor and reference model, sampled on the falling edge.
    always @(negedge clock) begin
        logic [NREQ-1:0] exp_rr;
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        int              g;
        int              idx;
        bit              exp_v;
        bit              found;
        exp_t            e;
        cyc++;
        if (was_reset) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_flags", {rsp_lt, rsp_eq, rsp_gt}, 0);
            chk("rst_id", rsp_id, 0);
            chk("rst_bits", rsp_bits, 0);
        end
        exp_rr = '0;
        g = -1;
        if (!reset && !m_busy) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rr[g] = 1'b1;
        chk("req_ready", req_ready, exp_rr);
        chk("busy", busy, m_busy);
        exp_v = m_busy && q.size() > 0 && cyc >= q[0].due;
        chk("rsp_valid", rsp_valid, exp_v);
        if (rsp_valid && exp_v) begin
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_flags", {rsp_lt, rsp_eq, rsp_gt},
                {q[0].lt, q[0].eq, q[0].gt});
            chk("rsp_bits", rsp_bits, q[0].bits);
        end
        if (!rsp_valid) chk("flags_idle", {rsp_lt, rsp_eq, rsp_gt}, 0);
        if (reset) begin
            q.delete();
            m_busy = 1'b0;
            m_last = NREQ - 1;
        end else if (exp_v && rsp_ready) begin
            void'(q.pop_front());
            m_busy = 1'b0;
        end else if (g >= 0) begin
            a = req_a[g*W +: W];
            b = req_b[g*W +: W];
            e.id = g;
            e.lt = a < b;
            e.eq = a == b;
            e.gt = a > b;
            e.bits = W;
            found = 1'b0;
            for (int i = W - 1; i >= 0; i--) begin
                if (!found && a[i] != b[i]) begin
                    found = 1'b1;
                    e.bits = W - i;
                end
            end
            e.due = cyc + 1 + e.bits;
            q.push_back(e);
            m_busy = 1'b1;
            m_last = g;
        end
        was_reset = reset;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(int i, logic [W-1:0] a, logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid = NREQ'(1) << i;
        step();
        req_valid = '0;
        repeat (W + 3) step();
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
        send(0, 8'hA5, 8'hA5);
        send(2, 8'h80, 8'h7F);
        send(0, 8'h12, 8'h13);
        send(3, 8'h00, 8'hFF);
        req_valid = 4'b1011;
        repeat (30) begin
            req_a = NREQ*W'({$urandom});
            req_b = NREQ*W'({$urandom});
            step();
        end
        req_valid = '0;
        repeat (W + 3) step();
        rsp_ready = 1'b0;
        send(1, 8'h55, 8'h55);
        repeat (5) step();
        rsp_ready = 1'b1;
        repeat (3) step();
        req_a = {NREQ{8'h3C}};
        req_b = {NREQ{8'h3C}};
        req_valid = 4'b1111;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (W + 4) step();
        req_valid = '0;
        repeat (W + 3) step();
        repeat (400) begin
            reset = $urandom_range(0, 99) == 0;
            req_valid = NREQ'($urandom);
            req_a = NREQ*W'({$urandom});
            req_b = $urandom_range(0, 3) == 0 ? req_a : NREQ*W'({$urandom});
            rsp_ready = $urandom_range(0, 3) != 0;
            step();
        end
        reset = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2 * W + 5) step();
        chk("drain", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_compare_arbiter.md
SERIAL_COMPARE_ARBITER -- requirements
Module: serial_compare_arbiter

Interface
REQ-001 SHALL have parameter W, default 8: operand width in bits (W >= 1).
REQ-002 SHALL have parameter NREQ, default 4: number of requesters (NREQ >= 2).
REQ-003 SHALL have port clock, input, 1: rising-edge clock.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, NREQ: per-requester compare request.
REQ-006 SHALL have port req_a, input, NREQ*W: operand A per requester; requester i uses bits [i*W+W-1 : i*W].
REQ-007 SHALL have port req_b, input, NREQ*W: operand B per requester, packed the same way as req_a.
REQ-008 SHALL have port req_ready, input-accept, output, NREQ: one-hot accept pulse for the granted requester.
REQ-009 SHALL have port rsp_valid, output, 1: result available.
REQ-010 SHALL have port rsp_ready, input, 1: consumer accepts result.
REQ-011 SHALL have port rsp_id, output, clog2(NREQ): index of the requester that owns the result.
REQ-012 SHALL have ports rsp_lt, rsp_eq, rsp_gt, output, 1 each: A<B, A==B, A>B (unsigned).
REQ-013 SHALL have port rsp_bits, output, clog2(W+1): number of bits examined before the decision (1..W).
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, COMPARE, RESPOND; reset state is IDLE.
REQ-016 In IDLE with any req_valid high, SHALL grant round-robin, searching from last_grant+1 (mod NREQ) upward.
REQ-017 In the grant cycle, SHALL drive req_ready[g]=1 combinationally, latch req_a/req_b slice g, g and a bit counter set to W, set last_grant=g, and enter COMPARE.
REQ-018 req_ready SHALL be all-zero outside IDLE and in IDLE when req_valid is all-zero; the block accepts at most one request per grant.
REQ-019 In COMPARE, SHALL examine one bit pair per cycle, MSB first, then shift both operands left by one and decrement the counter.
REQ-020 On the first differing bit, SHALL register lt=b_bit, gt=a_bit, and rsp_bits = the number of bits examined, and enter RESPOND; the remaining bits are not examined.
REQ-021 When all W bits are equal, SHALL register eq=1 and rsp_bits=W and enter RESPOND.
REQ-022 Latency: for a grant at cycle t and first difference at MSB-relative index d (0-based), rsp_valid SHALL first be high at t+2+d; for equal operands it SHALL first be high at t+W+1.
REQ-023 In RESPOND, rsp_valid=1; rsp_id, rsp_lt, rsp_eq, rsp_gt and rsp_bits SHALL hold stable until rsp_valid and rsp_ready are both high.
REQ-024 On rsp_valid&&rsp_ready, SHALL return to IDLE; the earliest next grant is the following cycle, with no grant in the handshake cycle.
REQ-025 When rsp_valid=1, exactly one of rsp_lt/rsp_eq/rsp_gt SHALL be high; when rsp_valid=0, all three SHALL be 0.
REQ-026 Changes on req_a/req_b/req_valid after the grant SHALL NOT affect the in-flight comparison.
REQ-027 A requester that drops req_valid before being granted SHALL NOT be granted; there is no pending-request memory.

Reset
REQ-028 reset SHALL dominate all other inputs in any state.
REQ-029 After reset: state=IDLE, rsp_valid=0, rsp_lt/eq/gt=0, rsp_id=0, rsp_bits=0, busy=0, last_grant=NREQ-1, so requester 0 has top priority.
REQ-030 Reset during COMPARE or RESPOND SHALL discard the in-flight request with no response; the requester is not re-notified.
REQ-031 req_ready SHALL be all-zero in any cycle where reset is high.

Verification (W=8, NREQ=4)
REQ-032 Only req_valid[0] is high with A=0xA5, B=0xA5, granted at cycle t -> rsp_valid at t+9 with eq=1, id=0, bits=8.
REQ-033 Only req_valid[2] is high with A=0x80, B=0x7F -> rsp_valid at t+2 with gt=1, id=2, bits=1.
REQ-034 A=0x12, B=0x13 -> lt=1, bits=8, rsp_valid at t+9.
REQ-035 req_valid=4'b1011 held, rsp_ready=1 -> grant order 0,1,3,0,1; no two grants less than 3 cycles apart.
REQ-036 rsp_ready held low for 5 cycles in RESPOND -> all rsp_* stable, req_ready=0, busy=1; IDLE is entered the cycle after rsp_ready rises.
REQ-037 reset pulsed mid-COMPARE with req_valid=4'b1111 -> next cycle all outputs are at reset values, no response is produced, and the next grant goes to requester 0.
